// File: rtl/pll_reset_sequencer.sv
// Staged reset release after PLL lock: RAM first, then cache/decoder, then CPU.
// Any loss of synchronised lock drops every reset back to asserted.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int STAGE_GAP     = 16,
  parameter int RAM_TIMEOUT   = 65535
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       ram_init_done,
  output logic       rst_ram,
  output logic       rst_cache,
  output logic       rst_cpu,
  output logic       ready,
  output logic       ram_timeout,
  output logic [7:0] lock_loss_count
);

  localparam int MAX_AB  = (STABLE_CYCLES > STAGE_GAP) ? STABLE_CYCLES : STAGE_GAP;
  localparam int MAX_CNT = (MAX_AB > RAM_TIMEOUT) ? MAX_AB : RAM_TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] RAM_LAST    = CNT_W'(RAM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    RAM_INIT  = 3'd2,
    CACHE_GAP = 3'd3,
    RUN       = 3'd4
  } stateT;

  stateT                   stateR;
  stateT                   nextStateS;
  logic [CNT_W-1:0]        cntR;
  logic [CNT_W-1:0]        cntNextS;
  logic [SYNC_STAGES-1:0]  syncR;
  logic                    lockS;
  logic                    timeoutHitS;
  logic                    lossS;
  logic                    rstRamS;
  logic                    rstCacheS;
  logic                    rstCpuS;
  logic                    readyS;

  assign lockS = syncR[SYNC_STAGES-1];
  assign lossS = (stateR != WAIT_LOCK) && !lockS;

  // Lock synchroniser, state register and shared counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      syncR  <= {SYNC_STAGES{1'b0}};
      stateR <= WAIT_LOCK;
      cntR   <= CNT_ZERO;
    end else begin
      syncR  <= {syncR[SYNC_STAGES-2:0], pll_locked};
      stateR <= nextStateS;
      cntR   <= cntNextS;
    end
  end

  // Next-state and counter logic; lock loss outranks every other exit
  always_comb begin
    nextStateS  = stateR;
    cntNextS    = cntR + CNT_ONE;
    timeoutHitS = 1'b0;
    case (stateR)
      WAIT_LOCK: begin
        cntNextS = CNT_ZERO;
        if (lockS) nextStateS = STABLE;
        else       nextStateS = WAIT_LOCK;
      end
      STABLE: begin
        if (!lockS) begin
          nextStateS = WAIT_LOCK;
          cntNextS   = CNT_ZERO;
        end else if (cntR == STABLE_LAST) begin
          nextStateS = RAM_INIT;
          cntNextS   = CNT_ZERO;
        end else begin
          nextStateS = STABLE;
        end
      end
      RAM_INIT: begin
        if (!lockS) begin
          nextStateS = WAIT_LOCK;
          cntNextS   = CNT_ZERO;
        end else if (ram_init_done) begin
          nextStateS = CACHE_GAP;
          cntNextS   = CNT_ZERO;
        end else if (cntR == RAM_LAST) begin
          nextStateS  = CACHE_GAP;
          cntNextS    = CNT_ZERO;
          timeoutHitS = 1'b1;
        end else begin
          nextStateS = RAM_INIT;
        end
      end
      CACHE_GAP: begin
        if (!lockS) begin
          nextStateS = WAIT_LOCK;
          cntNextS   = CNT_ZERO;
        end else if (cntR == GAP_LAST) begin
          nextStateS = RUN;
          cntNextS   = CNT_ZERO;
        end else begin
          nextStateS = CACHE_GAP;
        end
      end
      RUN: begin
        cntNextS = CNT_ZERO;
        if (!lockS) nextStateS = WAIT_LOCK;
        else        nextStateS = RUN;
      end
      default: begin
        nextStateS = WAIT_LOCK;
        cntNextS   = CNT_ZERO;
      end
    endcase
  end

  // Output decode from the upcoming state
  always_comb begin
    rstRamS   = 1'b1;
    rstCacheS = 1'b1;
    rstCpuS   = 1'b1;
    readyS    = 1'b0;
    case (nextStateS)
      WAIT_LOCK, STABLE: begin
        rstRamS = 1'b1;
      end
      RAM_INIT: begin
        rstRamS = 1'b0;
      end
      CACHE_GAP: begin
        rstRamS   = 1'b0;
        rstCacheS = 1'b0;
      end
      RUN: begin
        rstRamS   = 1'b0;
        rstCacheS = 1'b0;
        rstCpuS   = 1'b0;
        readyS    = 1'b1;
      end
      default: begin
        rstRamS = 1'b1;
      end
    endcase
  end

  // Registered outputs, so they move on the same edge as the state change
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rst_ram         <= 1'b1;
      rst_cache       <= 1'b1;
      rst_cpu         <= 1'b1;
      ready           <= 1'b0;
      ram_timeout     <= 1'b0;
      lock_loss_count <= 8'd0;
    end else begin
      rst_ram   <= rstRamS;
      rst_cache <= rstCacheS;
      rst_cpu   <= rstCpuS;
      ready     <= readyS;
      if (timeoutHitS) ram_timeout <= 1'b1;
      if (lossS && (lock_loss_count != 8'd255)) lock_loss_count <= lock_loss_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboarded bench: a timestamp-based reference model predicts every cycle's
// outputs into a queue; a negedge monitor pops and compares.
module tb_pll_reset_sequencer;
  localparam int SS  = 2;
  localparam int SC  = 8;
  localparam int GAP = 4;
  localparam int TMO = 32;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pll_locked = 1'b0;
  logic       ram_init_done = 1'b0;
  logic       rst_ram, rst_cache, rst_cpu, ready, ram_timeout;
  logic [7:0] lock_loss_count;

  pll_reset_sequencer #(
    .SYNC_STAGES(SS), .STABLE_CYCLES(SC), .STAGE_GAP(GAP), .RAM_TIMEOUT(TMO)
  ) dut (
    .clock(clock), .reset(reset), .pll_locked(pll_locked), .ram_init_done(ram_init_done),
    .rst_ram(rst_ram), .rst_cache(rst_cache), .rst_cpu(rst_cpu), .ready(ready),
    .ram_timeout(ram_timeout), .lock_loss_count(lock_loss_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       rr;
    logic       rc;
    logic       rcpu;
    logic       rdy;
    logic       tmo;
    logic [7:0] cnt;
  } expT;

  expT expQ[$];
  int  checks = 0;
  int  errors = 0;

  // Reference model: sequence progress tracked as edge timestamps
  bit hist[SS];
  bit inSeq, ramRel, cacheRel, cpuRel, mTmo;
  int mLoss, n, t0, tRam, tCache;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < SS; i++) hist[i] = 1'b0;
    inSeq = 0; ramRel = 0; cacheRel = 0; cpuRel = 0; mTmo = 0;
    mLoss = 0; n = 0; t0 = 0; tRam = 0; tCache = 0;
  endfunction

  function automatic void modelStep(bit pl, bit done);
    bit ls;
    ls = hist[SS-1];
    if (!inSeq) begin
      if (ls) begin inSeq = 1; t0 = n; end
    end else if (!ls) begin
      inSeq = 0; ramRel = 0; cacheRel = 0; cpuRel = 0;
      if (mLoss < 255) mLoss++;
    end else if (!ramRel) begin
      if (n - t0 == SC) begin ramRel = 1; tRam = n; end
    end else if (!cacheRel) begin
      if (done) begin
        cacheRel = 1; tCache = n;
      end else if (n - tRam == TMO) begin
        cacheRel = 1; tCache = n; mTmo = 1;
      end
    end else if (!cpuRel) begin
      if (n - tCache == GAP) cpuRel = 1;
    end
    for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = pl;
    n++;
  endfunction

  function automatic expT modelOut();
    expT e;
    e.rr = !ramRel; e.rc = !cacheRel; e.rcpu = !cpuRel; e.rdy = cpuRel;
    e.tmo = mTmo; e.cnt = 8'(mLoss);
    return e;
  endfunction

  // Monitor: compare DUT outputs with the oldest prediction
  always @(negedge clock) begin
    expT e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      check("outputs", {19'd0, rst_ram, rst_cache, rst_cpu, ready, ram_timeout, lock_loss_count},
            {19'd0, e});
    end
  end

  task automatic tick();
    @(posedge clock);
    modelStep(pll_locked, ram_init_done);
    expQ.push_back(modelOut());
    #1;
  endtask

  task automatic doReset();
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    check("async_reset", {26'd0, rst_ram, rst_cache, rst_cpu, ready, ram_timeout},
          {26'd0, 5'b11100});
    check("async_reset_count", {24'd0, lock_loss_count}, 32'd0);
    modelReset();
    pll_locked = 1'b0;
    ram_init_done = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic waitLow(string name, ref logic sig);
    int k;
    k = 0;
    while (sig !== 1'b0 && k < 200) begin tick(); k++; end
    check(name, {31'd0, sig}, 32'd0);
  endtask

  task automatic seqNominal();
    pll_locked = 1'b1;
    for (int e = 0; e <= 24; e++) begin
      ram_init_done = (e >= 16);
      tick();
      if (e == 9)  check("ram_before_10", {31'd0, rst_ram}, 32'd1);
      if (e == 10) check("ram_at_10", {31'd0, rst_ram}, 32'd0);
      if (e == 15) check("cache_before_16", {31'd0, rst_cache}, 32'd1);
      if (e == 16) check("cache_at_16", {31'd0, rst_cache}, 32'd0);
      if (e == 19) check("cpu_before_20", {30'd0, rst_cpu, ready}, 32'd2);
      if (e == 20) check("cpu_at_20", {30'd0, rst_cpu, ready}, 32'd1);
    end
  endtask

  initial begin
    int k;
    modelReset();
    doReset();

    // nominal release timeline
    seqNominal();

    // one-cycle lock drop in STABLE
    doReset();
    pll_locked = 1'b1;
    repeat (5) tick();
    pll_locked = 1'b0; tick();
    pll_locked = 1'b1;
    repeat (4) tick();
    check("glitch_ram_held", {31'd0, rst_ram}, 32'd1);
    check("glitch_loss", {24'd0, lock_loss_count}, 32'd1);
    waitLow("glitch_ram_release", rst_ram);

    // RAM wait timeout
    doReset();
    pll_locked = 1'b1;
    waitLow("tmo_ram_release", rst_ram);
    k = 0;
    while (rst_cache !== 1'b0 && k < 100) begin tick(); k++; end
    check("tmo_cycles", k, 32'd32);
    check("tmo_flag", {31'd0, ram_timeout}, 32'd1);
    k = 0;
    while (rst_cpu !== 1'b0 && k < 100) begin tick(); k++; end
    check("tmo_cpu_gap", k, 32'd4);

    // done coincides with timeout terminal count
    doReset();
    pll_locked = 1'b1;
    waitLow("tie_ram_release", rst_ram);
    repeat (31) tick();
    ram_init_done = 1'b1; tick();
    check("tie_cache", {31'd0, rst_cache}, 32'd0);
    check("tie_no_timeout", {31'd0, ram_timeout}, 32'd0);
    ram_init_done = 1'b0;

    // lock loss in RUN, then saturate the loss counter
    waitLow("run_reach", rst_cpu);
    pll_locked = 1'b0;
    k = 0;
    do begin tick(); k++; end while (rst_cpu === 1'b0 && k < 10);
    check("run_loss_latency", k, 32'd3);
    check("run_loss_outs", {28'd0, rst_ram, rst_cache, rst_cpu, ready}, 32'he);
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b1; repeat (3) tick();
      pll_locked = 1'b0; repeat (3) tick();
    end
    check("loss_saturate", {24'd0, lock_loss_count}, 32'd255);

    // lock loss and done together in RAM_INIT
    doReset();
    pll_locked = 1'b1;
    waitLow("both_ram_release", rst_ram);
    pll_locked = 1'b0;
    repeat (2) tick();
    ram_init_done = 1'b1; tick();
    check("both_cache_held", {30'd0, rst_ram, rst_cache}, 32'd3);
    ram_init_done = 1'b0;

    // reset in CACHE_GAP with sticky flags set, then full repeat
    pll_locked = 1'b1;
    waitLow("gap_reach", rst_cache);
    tick();
    doReset();
    seqNominal();

    // randomized traffic
    pll_locked = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) doReset();
      if (pll_locked) pll_locked = ($urandom_range(0, 79) != 0);
      else            pll_locked = ($urandom_range(0, 3) == 0);
      ram_init_done = ($urandom_range(0, 15) == 0);
      tick();
    end

    @(negedge clock);
    #1;
    check("queue_drained", expQ.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
